// File: rtl/fc_layer_scheduler_pkg.sv
// Shared types and constants for the fully-connected layer scheduler and its MAC.
package fc_layer_scheduler_pkg;

  typedef enum logic [1:0] {
    S_FILL  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_EMIT  = 2'd3
  } state_e;

  localparam int FC_IN_NUM = 75;
  localparam int ACC_BITS  = 24;
  localparam int OUT_LSB   = 7;
  localparam int ROM_LAT   = 1;
  localparam int LANE_BITS = 12;
  localparam int ADDR_BITS = 10;
  localparam int K_BITS    = 7;

endpackage

// File: rtl/fc_layer_scheduler_mac.sv
// Registered signed multiply-accumulate: load starts a new sum from the bias,
// accumulate adds the next product; the accumulator wraps at ACC_BITS.
module fc_mac_unit
  import fc_layer_scheduler_pkg::*;
#(
  parameter int DATA_BITS = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        en_i,
  input  logic                        load_i,
  input  logic signed [DATA_BITS-1:0] w_i,
  input  logic signed [DATA_BITS-1:0] b_i,
  input  logic signed [LANE_BITS-1:0] x_i,
  output logic        [LANE_BITS-1:0] res_next_o
);

  logic signed [ACC_BITS-1:0] w_ext, x_ext, b_ext, prod;
  logic signed [ACC_BITS-1:0] acc_d, acc_q;

  // Next accumulator value; the result slice is taken from it so the caller
  // can register the finished sum in the same cycle the last product lands.
  always_comb begin
    w_ext = {{(ACC_BITS-DATA_BITS){w_i[DATA_BITS-1]}}, w_i};
    b_ext = {{(ACC_BITS-DATA_BITS){b_i[DATA_BITS-1]}}, b_i};
    x_ext = {{(ACC_BITS-LANE_BITS){x_i[LANE_BITS-1]}}, x_i};
    prod  = w_ext * x_ext;
    if (!en_i) begin
      acc_d = acc_q;
    end else if (load_i) begin
      acc_d = b_ext + prod;
    end else begin
      acc_d = acc_q + prod;
    end
    res_next_o = acc_d[OUT_LSB+LANE_BITS-1:OUT_LSB];
  end

  // Accumulator register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/fc_layer_scheduler.sv
// Buffers one 75-element frame, then streams weights from ROM through a MAC to
// produce OUTPUT_NUM class scores with a ready/valid result handshake.
module fc_layer_scheduler
  import fc_layer_scheduler_pkg::*;
#(
  parameter int IN_WIDTH   = 25,
  parameter int OUTPUT_NUM = 10,
  parameter int DATA_BITS  = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        valid_in,
  output logic                        in_ready,
  input  logic signed [11:0]          data_in_1,
  input  logic signed [11:0]          data_in_2,
  input  logic signed [11:0]          data_in_3,
  output logic        [9:0]           w_addr,
  input  logic signed [DATA_BITS-1:0] w_data,
  output logic        [3:0]           b_addr,
  input  logic signed [DATA_BITS-1:0] b_data,
  output logic        [11:0]          data_out,
  output logic        [3:0]           class_idx,
  output logic                        valid_out,
  input  logic                        out_ready,
  output logic                        frame_done
);

  localparam int BEAT_BITS = $clog2(IN_WIDTH);

  state_e                 state_q, state_d;
  logic [BEAT_BITS-1:0]   beat_q, beat_d;
  logic [K_BITS-1:0]      k_q, k_d;
  logic [3:0]             out_idx_q, out_idx_d;
  logic [1:0]             wait_q, wait_d;
  logic                   mac_en_q, mac_en_d, mac_load_q, mac_load_d;
  logic signed [LANE_BITS-1:0] mac_x_q, mac_x_d;
  logic                   in_ready_q, in_ready_d, valid_out_q, valid_out_d;
  logic                   frame_done_q, frame_done_d;
  logic [11:0]            data_out_q, data_out_d;
  logic [3:0]             class_idx_q, class_idx_d, b_addr_q, b_addr_d;
  logic [ADDR_BITS-1:0]   w_addr_q, w_addr_d;
  logic [LANE_BITS-1:0]   res_next_s;
  logic [K_BITS-1:0]      buf_idx_s;
  logic                   fill_we_s;
  logic signed [LANE_BITS-1:0] buffer_q [0:FC_IN_NUM-1];

  assign buf_idx_s = K_BITS'(beat_q);
  assign fill_we_s = (state_q == S_FILL) && valid_in;

  // Frame buffer: lane n of beat b lands at n*IN_WIDTH + b; contents need no reset.
  always_ff @(posedge clk) begin
    if (fill_we_s) begin
      buffer_q[buf_idx_s]                      <= data_in_1;
      buffer_q[buf_idx_s + K_BITS'(IN_WIDTH)]  <= data_in_2;
      buffer_q[buf_idx_s + K_BITS'(2*IN_WIDTH)] <= data_in_3;
    end
  end

  // Scheduler next-state: the MAC operands are delayed one cycle to meet the ROM data.
  always_comb begin
    state_d      = state_q;
    beat_d       = beat_q;
    k_d          = k_q;
    out_idx_d    = out_idx_q;
    wait_d       = wait_q;
    mac_en_d     = 1'b0;
    mac_load_d   = 1'b0;
    mac_x_d      = mac_x_q;
    valid_out_d  = valid_out_q;
    frame_done_d = 1'b0;
    data_out_d   = data_out_q;
    class_idx_d  = class_idx_q;
    case (state_q)
      S_FILL: begin
        if (valid_in && (beat_q == BEAT_BITS'(IN_WIDTH-1))) begin
          beat_d    = '0;
          k_d       = '0;
          out_idx_d = 4'd0;
          state_d   = S_ISSUE;
        end else if (valid_in) begin
          beat_d = beat_q + BEAT_BITS'(1);
        end else begin
          beat_d = beat_q;
        end
      end
      S_ISSUE: begin
        mac_en_d   = 1'b1;
        mac_load_d = (k_q == K_BITS'(0));
        mac_x_d    = buffer_q[k_q];
        if (k_q == K_BITS'(FC_IN_NUM-1)) begin
          k_d     = '0;
          wait_d  = 2'd0;
          state_d = S_WAIT;
        end else begin
          k_d = k_q + K_BITS'(1);
        end
      end
      S_WAIT: begin
        if (wait_q == 2'(ROM_LAT-1)) begin
          state_d     = S_EMIT;
          valid_out_d = 1'b1;
          data_out_d  = res_next_s;
          class_idx_d = out_idx_q;
        end else begin
          wait_d = wait_q + 2'd1;
        end
      end
      S_EMIT: begin
        if (out_ready && (out_idx_q == 4'(OUTPUT_NUM-1))) begin
          valid_out_d  = 1'b0;
          frame_done_d = 1'b1;
          out_idx_d    = 4'd0;
          k_d          = '0;
          beat_d       = '0;
          state_d      = S_FILL;
        end else if (out_ready) begin
          valid_out_d = 1'b0;
          out_idx_d   = out_idx_q + 4'd1;
          k_d         = '0;
          state_d     = S_ISSUE;
        end else begin
          valid_out_d = 1'b1;
        end
      end
      default: state_d = S_FILL;
    endcase
    in_ready_d = (state_d == S_FILL);
    if (state_d == S_ISSUE) begin
      w_addr_d = ADDR_BITS'(out_idx_d) * ADDR_BITS'(FC_IN_NUM) + ADDR_BITS'(k_d);
    end else begin
      w_addr_d = w_addr_q;
    end
    if ((state_d == S_ISSUE) && (k_d == K_BITS'(0))) begin
      b_addr_d = out_idx_d;
    end else begin
      b_addr_d = b_addr_q;
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_FILL;
      beat_q       <= '0;
      k_q          <= '0;
      out_idx_q    <= 4'd0;
      wait_q       <= 2'd0;
      mac_en_q     <= 1'b0;
      mac_load_q   <= 1'b0;
      mac_x_q      <= '0;
      in_ready_q   <= 1'b1;
      valid_out_q  <= 1'b0;
      frame_done_q <= 1'b0;
      data_out_q   <= 12'd0;
      class_idx_q  <= 4'd0;
      w_addr_q     <= '0;
      b_addr_q     <= 4'd0;
    end else begin
      state_q      <= state_d;
      beat_q       <= beat_d;
      k_q          <= k_d;
      out_idx_q    <= out_idx_d;
      wait_q       <= wait_d;
      mac_en_q     <= mac_en_d;
      mac_load_q   <= mac_load_d;
      mac_x_q      <= mac_x_d;
      in_ready_q   <= in_ready_d;
      valid_out_q  <= valid_out_d;
      frame_done_q <= frame_done_d;
      data_out_q   <= data_out_d;
      class_idx_q  <= class_idx_d;
      w_addr_q     <= w_addr_d;
      b_addr_q     <= b_addr_d;
    end
  end

  fc_mac_unit #(.DATA_BITS(DATA_BITS)) u_mac (
    .clk        (clk),
    .rst_n      (rst_n),
    .en_i       (mac_en_q),
    .load_i     (mac_load_q),
    .w_i        (w_data),
    .b_i        (b_data),
    .x_i        (mac_x_q),
    .res_next_o (res_next_s)
  );

  assign in_ready   = in_ready_q;
  assign valid_out  = valid_out_q;
  assign frame_done = frame_done_q;
  assign data_out   = data_out_q;
  assign class_idx  = class_idx_q;
  assign w_addr     = w_addr_q;
  assign b_addr     = b_addr_q;

endmodule

// File: tb/tb_fc_layer_scheduler.sv
// Directed bench: ROM models, a frame-level arithmetic model feeding a result
// scoreboard, and one negedge compare process.
module tb_fc_layer_scheduler;

  localparam int NCLS = 10;
  localparam int NIN  = 75;

  logic        clk = 1'b0;
  logic        rst_n, valid_in, out_ready;
  logic [11:0] d1, d2, d3;
  logic [9:0]  w_addr;
  logic [3:0]  b_addr, class_idx;
  logic [7:0]  w_data, b_data;
  logic [11:0] data_out;
  logic        in_ready, valid_out, frame_done;

  typedef struct packed {logic [3:0] cls; logic [11:0] data;} exp_t;

  byte         wrom [0:NCLS*NIN-1];
  byte         brom [0:NCLS-1];
  logic [11:0] fbuf [0:NIN-1];
  exp_t        sbq [$];
  exp_t        pe;
  int          total = 0, bad = 0, cyc = 0, n_acc = 0;
  int          t_last_beat = 0, t_last_valid = 0, t_fd = 0;
  logic        held = 1'b0, fd_exp = 1'b0;
  logic [11:0] held_data;
  logic [3:0]  held_cls;

  fc_layer_scheduler dut (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .in_ready(in_ready),
    .data_in_1(d1), .data_in_2(d2), .data_in_3(d3),
    .w_addr(w_addr), .w_data(w_data), .b_addr(b_addr), .b_data(b_data),
    .data_out(data_out), .class_idx(class_idx), .valid_out(valid_out),
    .out_ready(out_ready), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc    <= cyc + 1;
    w_data <= (w_addr < 10'd750) ? wrom[w_addr] : 8'd0;
    b_data <= (b_addr < 4'd10) ? brom[b_addr] : 8'd0;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Class score straight from the arithmetic: bias + dot product, wrapped to 24 bits.
  function automatic logic [11:0] model_out(input int c);
    longint s;
    logic [23:0] a;
    s = longint'(brom[c]);
    for (int k = 0; k < NIN; k++)
      s = s + longint'(wrom[c*NIN+k]) * longint'($signed(fbuf[k]));
    a = s[23:0];
    return a[18:7];
  endfunction

  task automatic load_rom(input int mode, input byte w, input byte b);
    for (int i = 0; i < NCLS*NIN; i++) wrom[i] = (mode == 0) ? w : byte'((i*13) % 31 - 15);
    for (int c = 0; c < NCLS; c++) brom[c] = (mode == 0) ? b : byte'(c*11 - 50);
  endtask

  task automatic load_lanes(input int mode, input logic [11:0] v);
    for (int i = 0; i < NIN; i++) fbuf[i] = (mode == 0) ? v : 12'((i*97) % 2048 - 1024);
  endtask

  task automatic send_frame();
    exp_t e;
    int n = 0;
    while (!in_ready && n < 1000) begin @(posedge clk); #1; n++; end
    if (!in_ready) begin total++; bad++; $display("FAIL in_ready_wait: actual=0 expected=1"); end
    n_acc = 0;
    for (int c = 0; c < NCLS; c++) begin
      e.cls = 4'(c); e.data = model_out(c); sbq.push_back(e);
    end
    for (int b = 0; b < 25; b++) begin
      valid_in = 1'b1; d1 = fbuf[b]; d2 = fbuf[25+b]; d3 = fbuf[50+b];
      @(negedge clk);
      if (b == 24) t_last_beat = cyc;
      @(posedge clk); #1;
    end
    valid_in = 1'b0; d1 = 12'($urandom); d2 = 12'($urandom); d3 = 12'($urandom);
  endtask

  task automatic wait_frame(input int lat);
    int n = 0;
    do begin @(negedge clk); n++; end while (!frame_done && n < 3000);
    if (!frame_done) begin total++; bad++; $display("FAIL frame_timeout: actual=0 expected=1"); end
    t_fd = cyc;
    check("n_accepted", 32'(n_acc), 32'(NCLS));
    check("sb_empty", 32'(sbq.size()), 32'd0);
    check("latency", 32'(t_last_valid - t_last_beat), 32'(lat));
    check("fd_timing", 32'(t_fd - t_last_valid), 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic check_reset_outputs();
    check("rst_valid_out", 32'(valid_out), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    check("rst_data_out", 32'(data_out), 32'd0);
    check("rst_class_idx", 32'(class_idx), 32'd0);
    check("rst_w_addr", 32'(w_addr), 32'd0);
    check("rst_b_addr", 32'(b_addr), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
  endtask

  // Single compare process: scoreboard on acceptance, hold stability, frame_done pulse.
  always @(negedge clk) begin
    if (!rst_n) begin
      held = 1'b0; fd_exp = 1'b0;
    end else begin
      check("frame_done", 32'(frame_done), 32'(fd_exp));
      fd_exp = 1'b0;
      if (valid_out) begin
        if (held) begin
          check("hold_data", 32'(data_out), 32'(held_data));
          check("hold_cls", 32'(class_idx), 32'(held_cls));
        end else if (class_idx == 4'(NCLS-1)) begin
          t_last_valid = cyc;
        end
        if (out_ready) begin
          held = 1'b0;
          if (sbq.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_result: actual=%0h expected=none", data_out);
          end else begin
            pe = sbq.pop_front();
            check("data_out", 32'(data_out), 32'(pe.data));
            check("class_idx", 32'(class_idx), 32'(pe.cls));
            n_acc++;
            fd_exp = (pe.cls == 4'(NCLS-1));
          end
        end else begin
          held = 1'b1; held_data = data_out; held_cls = class_idx;
        end
      end else begin
        held = 1'b0;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    rst_n = 1'b0; valid_in = 1'b0; out_ready = 1'b1;
    d1 = 12'd0; d2 = 12'd0; d3 = 12'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs();
    #2 rst_n = 1'b1;
    @(posedge clk); #1;

    // all ones: 75 * 128 >> 7 = 75 for every class
    load_lanes(0, 12'h080); load_rom(0, 8'sd1, 8'sd0);
    check("pin_ones", 32'(model_out(0)), 32'd75);
    send_frame(); wait_frame(770);
    check("in_ready_fill", 32'(in_ready), 32'd1);

    // weights -1: -9600 -> acc[18:7] = -75 = 12'hFB5
    load_rom(0, -8'sd1, 8'sd0);
    check("pin_neg", 32'(model_out(3)), 32'h0FB5);
    send_frame(); wait_frame(770);

    // mixed data with a 5-cycle stall on class 3
    load_lanes(1, 12'h000); load_rom(1, 8'sd0, 8'sd0);
    send_frame();
    n = 0;
    while (!(valid_out && class_idx == 4'd3) && n < 2000) begin @(posedge clk); #1; n++; end
    check("stall_reach", 32'(class_idx), 32'd3);
    out_ready = 1'b0;
    repeat (5) @(posedge clk);
    #1 check("stall_valid_held", 32'(valid_out), 32'd1);
    out_ready = 1'b1;
    wait_frame(775);

    // same frame, valid_in pulsed while issuing must be ignored
    send_frame();
    for (int i = 0; i < 4; i++) begin
      valid_in = 1'b1; d1 = 12'($urandom); d2 = 12'($urandom); d3 = 12'($urandom);
      @(negedge clk);
      check("in_ready_issue", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
    end
    valid_in = 1'b0;
    wait_frame(770);

    // reset at class 5, k = 40, then a fresh frame from class 0
    send_frame();
    n = 0;
    while (w_addr !== 10'd415 && n < 2000) begin @(posedge clk); #1; n++; end
    check("reset_point", 32'(w_addr), 32'd415);
    rst_n = 1'b0;
    sbq.delete();
    @(negedge clk);
    check_reset_outputs();
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    load_rom(0, 8'sd2, -8'sd3);
    send_frame(); wait_frame(770);

    // weights 0, bias 127: 127 >> 7 = 0
    load_lanes(0, 12'h080); load_rom(0, 8'sd0, 8'sd127);
    check("pin_bias", 32'(model_out(9)), 32'd0);
    send_frame(); wait_frame(770);

    // large products wrap the 24-bit accumulator: 75*2047*127 mod 2^24 >> 7 -> 773
    load_lanes(0, 12'h7FF); load_rom(0, 8'sd127, 8'sd0);
    check("pin_wrap", 32'(model_out(0)), 32'd773);
    send_frame(); wait_frame(770);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
